// File: rtl/pixel_frequency_analyzer_pkg.sv
// Shared types and helpers for the pixel frequency analyzer.
package pixel_frequency_analyzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // All-ones source; counters slice their own width from it as the saturation ceiling.
  localparam logic [63:0] SAT_ALL_ONES = '1;

  // Ceiling log2, minimum 1 bit, used for channel/read index widths.
  function automatic int idx_width(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/frequency_channel_counter.sv
// One range channel: programmable inclusive [low, high] window and a saturating hit counter.
module frequency_channel_counter
  import pixel_frequency_analyzer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 32,
  parameter int CH_ID         = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [DATA_WIDTH-1:0]    cfg_low,
  input  logic [DATA_WIDTH-1:0]    cfg_high,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     sample_en,
  input  logic                     clear,
  output logic [COUNTER_WIDTH-1:0] count
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = SAT_ALL_ONES[COUNTER_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] low, high;
  logic                  hit;

  // low > high naturally never matches, no special case needed.
  assign hit = sample_en && (data >= low) && (data <= high);

  // Range registers; out of reset each channel matches only its own index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low  <= DATA_WIDTH'(CH_ID);
      high <= DATA_WIDTH'(CH_ID);
    end else if (cfg_we) begin
      low  <= cfg_low;
      high <= cfg_high;
    end
  end

  // Saturating hit counter with synchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        count <= '0;
    else if (clear)                    count <= '0;
    else if (hit && count != CNT_MAX)  count <= count + 1'b1;
  end

endmodule

// File: rtl/pixel_frequency_analyzer.sv
// Multi-channel pixel value range counter with run control, auto-stop and a registered read port.
module pixel_frequency_analyzer
  import pixel_frequency_analyzer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_COUNT = 3,
  parameter int COUNTER_WIDTH = 32,
  parameter int CH_IDX_W      = idx_width(CHANNEL_COUNT + 1)
) (
  input  logic                     pixel_clock,
  input  logic                     pixel_aresetn,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     data_valid,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clear,
  input  logic [COUNTER_WIDTH-1:0] sample_limit,
  input  logic                     cfg_we,
  input  logic [CH_IDX_W-1:0]      cfg_channel,
  input  logic [DATA_WIDTH-1:0]    cfg_low,
  input  logic [DATA_WIDTH-1:0]    cfg_high,
  input  logic                     rd_en,
  input  logic [CH_IDX_W-1:0]      rd_addr,
  output logic [COUNTER_WIDTH-1:0] rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     irq
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = SAT_ALL_ONES[COUNTER_WIDTH-1:0];

  state_t                                     state;
  logic [COUNTER_WIDTH-1:0]                   run_samples, run_samples_inc, total, rd_mux;
  logic [CHANNEL_COUNT-1:0][COUNTER_WIDTH-1:0] ch_count;
  logic                                       in_run, sample_en, limit_hit, stop_evt, cfg_ok;

  assign in_run          = (state == ST_RUN);
  // A sample coinciding with clear is dropped.
  assign sample_en       = in_run && data_valid && !clear;
  assign run_samples_inc = (run_samples == CNT_MAX) ? run_samples : run_samples + 1'b1;
  assign limit_hit       = sample_en && (sample_limit != '0) && (run_samples_inc == sample_limit);
  assign stop_evt        = in_run && !clear && (stop || limit_hit);
  // Bounds are frozen while a run is in progress.
  assign cfg_ok          = cfg_we && !in_run;

  generate
    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_ch
      frequency_channel_counter #(
        .DATA_WIDTH   (DATA_WIDTH),
        .COUNTER_WIDTH(COUNTER_WIDTH),
        .CH_ID        (c)
      ) u_ch (
        .clk      (pixel_clock),
        .rst_n    (pixel_aresetn),
        .cfg_we   (cfg_ok && (cfg_channel == CH_IDX_W'(c))),
        .cfg_low  (cfg_low),
        .cfg_high (cfg_high),
        .data     (data),
        .sample_en(sample_en),
        .clear    (clear),
        .count    (ch_count[c])
      );
    end
  endgenerate

  // Run control: clear beats stop/limit, which beat start; also tracks run length and total.
  always_ff @(posedge pixel_clock or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      irq         <= 1'b0;
      run_samples <= '0;
      total       <= '0;
    end else begin
      irq <= 1'b0;
      if (clear) begin
        state       <= ST_IDLE;
        busy        <= 1'b0;
        run_samples <= '0;
        total       <= '0;
      end else if (in_run) begin
        if (data_valid) begin
          run_samples <= run_samples_inc;
          if (total != CNT_MAX) total <= total + 1'b1;
        end
        if (stop_evt) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          irq   <= 1'b1;
        end
      end else if (start) begin
        state       <= ST_RUN;
        busy        <= 1'b1;
        run_samples <= '0;
      end
    end
  end

  // Read select: channels, then the total, anything beyond reads as zero.
  always_comb begin
    rd_mux = '0;
    if (rd_addr == CH_IDX_W'(CHANNEL_COUNT)) rd_mux = total;
    for (int i = 0; i < CHANNEL_COUNT; i++)
      if (rd_addr == CH_IDX_W'(i)) rd_mux = ch_count[i];
  end

  // Registered read port; rd_data holds its last value between reads.
  always_ff @(posedge pixel_clock or negedge pixel_aresetn) begin
    if (!pixel_aresetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_pixel_frequency_analyzer.sv
// Bench: directed scenarios with literal expectations plus a random phase, all checked
// every cycle against a transaction-level reference model.
module tb_pixel_frequency_analyzer;
  localparam int DW  = 8;
  localparam int CC  = 4;   // CC+1 not a power of two, so out-of-range read addresses exist
  localparam int CW  = 5;   // small counters so saturation is reachable
  localparam int CIW = 3;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic            pixel_clock = 1'b0, pixel_aresetn = 1'b0;
  logic [DW-1:0]   data = '0, cfg_low = '0, cfg_high = '0;
  logic            data_valid = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [CW-1:0]   sample_limit = '0;
  logic            cfg_we = 1'b0, rd_en = 1'b0;
  logic [CIW-1:0]  cfg_channel = '0, rd_addr = '0;
  logic [CW-1:0]   rd_data;
  logic            rd_valid, busy, irq;

  int checks = 0, errors = 0;

  always #5 pixel_clock = ~pixel_clock;

  pixel_frequency_analyzer #(
    .DATA_WIDTH(DW), .CHANNEL_COUNT(CC), .COUNTER_WIDTH(CW)
  ) dut (
    .pixel_clock(pixel_clock), .pixel_aresetn(pixel_aresetn),
    .data(data), .data_valid(data_valid), .start(start), .stop(stop), .clear(clear),
    .sample_limit(sample_limit), .cfg_we(cfg_we), .cfg_channel(cfg_channel),
    .cfg_low(cfg_low), .cfg_high(cfg_high), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .irq(irq)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_mode: 0 idle, 1 counting, 2 finished
  int          m_mode;
  int unsigned m_cnt[CC], m_low[CC], m_high[CC];
  int unsigned m_total, m_rs, m_rd;
  bit          m_irq, m_busy, m_rv;

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_total = 0; m_rs = 0; m_rd = 0;
    m_irq = 0; m_busy = 0; m_rv = 0;
    for (int c = 0; c < CC; c++) begin
      m_cnt[c] = 0; m_low[c] = c % (1 << DW); m_high[c] = c % (1 << DW);
    end
  endtask

  task automatic model_step();
    int unsigned a;
    if (!pixel_aresetn) begin model_reset(); return; end
    a = rd_addr;
    m_rv = rd_en;
    if (rd_en) begin
      if (a < CC) m_rd = m_cnt[a];
      else if (a == CC) m_rd = m_total;
      else m_rd = 0;
    end
    if (cfg_we && m_mode != 1 && cfg_channel < CC) begin
      m_low[cfg_channel] = cfg_low; m_high[cfg_channel] = cfg_high;
    end
    m_irq = 0;
    if (clear) begin
      m_mode = 0; m_total = 0; m_rs = 0;
      for (int c = 0; c < CC; c++) m_cnt[c] = 0;
    end else if (m_mode == 1) begin
      if (data_valid) begin
        for (int c = 0; c < CC; c++)
          if (m_low[c] <= data && data <= m_high[c]) m_cnt[c] = sat_inc(m_cnt[c]);
        m_total = sat_inc(m_total);
        m_rs    = sat_inc(m_rs);
      end
      if (stop || (data_valid && sample_limit != 0 && m_rs == sample_limit)) begin
        m_mode = 2; m_irq = 1;
      end
    end else if (start) begin
      m_mode = 1; m_rs = 0;
    end
    m_busy = (m_mode == 1);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge pixel_clock or negedge pixel_aresetn);
      model_step();
    end
  end

  // Compare process: outputs against the model on every falling edge.
  initial forever begin
    @(negedge pixel_clock);
    chk("busy", busy, m_busy);
    chk("irq", irq, m_irq);
    chk("rd_valid", rd_valid, m_rv);
    if (m_rv) chk("rd_data", rd_data, m_rd);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge pixel_clock); #1;
  endtask

  task automatic rd_chk(input int a, input int unsigned exp, input string n);
    rd_en = 1'b1; rd_addr = CIW'(a); tick(); rd_en = 1'b0;
    chk(n, rd_data, exp);
    chk({n, "_valid"}, rd_valid, 1);
  endtask

  task automatic cfg(input int ch, input int lo, input int hi);
    cfg_we = 1'b1; cfg_channel = CIW'(ch); cfg_low = DW'(lo); cfg_high = DW'(hi);
    tick(); cfg_we = 1'b0;
  endtask

  task automatic stream(input int v);
    data = DW'(v); data_valid = 1'b1; tick(); data_valid = 1'b0;
  endtask

  task automatic pulse_start(); start = 1'b1; tick(); start = 1'b0; endtask
  task automatic pulse_clear(); clear = 1'b1; tick(); clear = 1'b0; endtask

  initial begin
    int seq1[5] = '{0, 1, 2, 2, 5};
    int seq2[5] = '{9, 10, 20, 21, 27};

    // Reset defaults
    tick(); tick();
    chk("rst_busy", busy, 0); chk("rst_irq", irq, 0);
    chk("rst_rd_valid", rd_valid, 0); chk("rst_rd_data", rd_data, 0);
    pixel_aresetn = 1'b1; tick();
    for (int i = 0; i <= CC; i++) rd_chk(i, 0, "rst_cnt");

    // Default single-value ranges
    pulse_start();
    chk("run_busy", busy, 1);
    foreach (seq1[i]) stream(seq1[i]);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_irq", irq, 1); chk("stop_busy", busy, 0);
    tick();
    chk("irq_one_cycle", irq, 0);
    rd_chk(0, 1, "s1_ch0"); rd_chk(1, 1, "s1_ch1"); rd_chk(2, 2, "s1_ch2");
    rd_chk(3, 0, "s1_ch3"); rd_chk(CC, 5, "s1_total");

    // Programmed ranges, including an inverted one
    pulse_clear();
    cfg(0, 10, 20); cfg(1, 30, 25);
    pulse_start();
    foreach (seq2[i]) stream(seq2[i]);
    stop = 1'b1; tick(); stop = 1'b0;
    rd_chk(0, 2, "s2_ch0"); rd_chk(1, 0, "s2_ch1"); rd_chk(CC, 5, "s2_total");

    // Auto-stop at sample_limit
    pulse_clear();
    cfg(0, 0, 0);
    sample_limit = 4;
    pulse_start();
    data = '0; data_valid = 1'b1;
    tick(); tick(); tick();
    chk("lim_busy_before", busy, 1);
    tick();
    chk("lim_irq", irq, 1); chk("lim_busy", busy, 0);
    tick(); tick();
    data_valid = 1'b0; sample_limit = '0;
    rd_chk(0, 4, "lim_ch0"); rd_chk(CC, 4, "lim_total");

    // start with clear
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    chk("startclr_busy", busy, 0);
    rd_chk(CC, 0, "startclr_total");
    // sample on the stop cycle is counted
    cfg(1, 1, 1);
    pulse_start();
    data = 8'd1; data_valid = 1'b1; stop = 1'b1; tick(); data_valid = 1'b0; stop = 1'b0;
    rd_chk(1, 1, "stopsmp_ch1"); rd_chk(CC, 1, "stopsmp_total");
    // config during a run is ignored
    pulse_start();
    cfg(1, 50, 60);
    stream(1);
    stop = 1'b1; tick(); stop = 1'b0;
    rd_chk(1, 2, "cfgrun_ch1");

    // Saturation, plus a read concurrent with an increment
    pulse_clear();
    pulse_start();
    for (int i = 0; i < 3; i++) stream(0);
    data = '0; data_valid = 1'b1; rd_en = 1'b1; rd_addr = CIW'(CC); tick(); rd_en = 1'b0;
    chk("concurrent_rd", rd_data, 3);
    for (int i = 0; i < 36; i++) tick();
    data_valid = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    rd_chk(0, CMAX, "sat_ch0"); rd_chk(CC, CMAX, "sat_total");
    for (int a = CC + 1; a < (1 << CIW); a++) rd_chk(a, 0, "oob_rd");

    // Random phase
    pulse_clear();
    for (int n = 0; n < 1500; n++) begin
      data        = DW'($urandom_range(0, 15));
      data_valid  = ($urandom_range(0, 9) < 7);
      start       = ($urandom_range(0, 9) == 0);
      stop        = ($urandom_range(0, 29) == 0);
      clear       = ($urandom_range(0, 99) == 0);
      cfg_we      = ($urandom_range(0, 19) == 0);
      cfg_channel = CIW'($urandom_range(0, 7));
      cfg_low     = DW'($urandom_range(0, 15));
      cfg_high    = DW'($urandom_range(0, 15));
      rd_en       = $urandom_range(0, 1) == 1;
      rd_addr     = CIW'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0)
        sample_limit = ($urandom_range(0, 1) == 1) ? CW'($urandom_range(1, 10)) : '0;
      tick();
    end
    {data_valid, start, stop, clear, cfg_we, rd_en} = '0;
    sample_limit = '0;

    // Reset in the middle of a run
    pulse_clear();
    cfg(0, 0, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) stream(0);
    data_valid = 1'b1;
    pixel_aresetn = 1'b0; #1;
    chk("midrst_busy", busy, 0); chk("midrst_irq", irq, 0); chk("midrst_rd_valid", rd_valid, 0);
    tick(); tick();
    data_valid = 1'b0;
    pixel_aresetn = 1'b1; tick();
    chk("postrst_irq", irq, 0);
    rd_chk(0, 0, "postrst_ch0"); rd_chk(CC, 0, "postrst_total");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
